// File: rtl/funcunit_pkg.sv
// Shared constants and types for the function-unit command sequencer.
// FS codes follow the function unit's encoding; flags are packed {V,C,N,Z}.
package funcunit_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_COUNT = 8;
    localparam int unsigned FLAG_W    = 4;

    localparam logic [3:0] FS_TRANSFER = 4'b0000;
    localparam logic [3:0] FS_INC      = 4'b0001;
    localparam logic [3:0] FS_ADD      = 4'b0010;
    localparam logic [3:0] FS_ADD_INC  = 4'b0011;
    localparam logic [3:0] FS_ADD_NOTB = 4'b0100;
    localparam logic [3:0] FS_SUB      = 4'b0101;
    localparam logic [3:0] FS_DEC      = 4'b0110;
    localparam logic [3:0] FS_TRANSF2  = 4'b0111;
    localparam logic [3:0] FS_AND      = 4'b1000;
    localparam logic [3:0] FS_OR       = 4'b1001;
    localparam logic [3:0] FS_XOR      = 4'b1010;
    localparam logic [3:0] FS_NOT      = 4'b1011;
    localparam logic [3:0] FS_LOAD_B   = 4'b1100;
    localparam logic [3:0] FS_SHR      = 4'b1101;
    localparam logic [3:0] FS_SHL      = 4'b1110;
    localparam logic [3:0] FS_HOLD     = 4'b1111;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StFlag,
        StMulAdd,
        StMulShl,
        StDone
    } state_t;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic v, input logic c,
                                                     input logic n, input logic z);
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/fu_regfile.sv
// Register file: two asynchronous read ports, one write port, R0 reads as zero.
// Whole array clears asynchronously on rst_n low.
module fu_regfile
    import funcunit_pkg::*;
#(
    parameter int unsigned NREG = REG_COUNT,
    parameter int unsigned DW   = DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(NREG)-1:0]  raddr_a,
    output logic [DW-1:0]            rdata_a,
    input  logic [$clog2(NREG)-1:0]  raddr_b,
    output logic [DW-1:0]            rdata_b
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/funcunit_ctrl.sv
// Command sequencer for the 16-bit function unit: single ops and an iterative multiply.
// Multiply macro-op is built only when FUNCUNIT_CTRL_MUL_EN is defined.
module funcunit_ctrl
    import funcunit_pkg::*;
#(
    parameter int unsigned NREG     = REG_COUNT,
    parameter int unsigned MUL_ITER = DATA_W
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_fs,
    input  logic                     cmd_mul,
    input  logic [$clog2(NREG)-1:0]  cmd_dst,
    input  logic [$clog2(NREG)-1:0]  cmd_srca,
    input  logic [$clog2(NREG)-1:0]  cmd_srcb,
    input  logic                     cmd_imm_sel,
    input  logic [DATA_W-1:0]        cmd_imm,
    output logic [3:0]               fu_fs,
    output logic [DATA_W-1:0]        fu_a,
    output logic [DATA_W-1:0]        fu_b,
    input  logic [DATA_W-1:0]        fu_d,
    input  logic [FLAG_W-1:0]        fu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [FLAG_W-1:0]        rsp_flags,
    output logic                     rsp_err
);

    localparam int unsigned AW = $clog2(NREG);

    state_t              state_q;
    logic [AW-1:0]       dst_q;
    logic [DATA_W-1:0]   res_q;
    logic                wb_q;
    logic [DATA_W-1:0]   rdata_a;
    logic [DATA_W-1:0]   rdata_b;
    logic [DATA_W-1:0]   opb;

`ifdef FUNCUNIT_CTRL_MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_ITER + 1);

    logic [DATA_W-1:0]   acc_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
`endif

    assign opb = cmd_imm_sel ? cmd_imm : rdata_b;

    // Writeback happens on the first DONE edge, so it lands before IDLE is re-entered.
    fu_regfile #(
        .NREG (NREG),
        .DW   (DATA_W)
    ) u_regfile (
        .clk     (CLK),
        .rst_n   (RESET),
        .we      (wb_q),
        .waddr   (dst_q),
        .wdata   (rsp_data),
        .raddr_a (cmd_srca),
        .rdata_a (rdata_a),
        .raddr_b (cmd_srcb),
        .rdata_b (rdata_b)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            fu_fs     <= FS_HOLD;
            fu_a      <= '0;
            fu_b      <= '0;
            dst_q     <= '0;
            res_q     <= '0;
            wb_q      <= 1'b0;
`ifdef FUNCUNIT_CTRL_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        dst_q     <= cmd_dst;
                        cmd_ready <= 1'b0;
                        if (!cmd_mul) begin
                            fu_fs   <= cmd_fs;
                            fu_a    <= rdata_a;
                            fu_b    <= opb;
                            state_q <= StExec;
                        end else begin
`ifdef FUNCUNIT_CTRL_MUL_EN
                            acc_q    <= '0;
                            mcand_q  <= rdata_a;
                            mplier_q <= opb;
                            cnt_q    <= '0;
                            fu_fs    <= opb[0] ? FS_ADD : FS_HOLD;
                            fu_a     <= '0;
                            fu_b     <= rdata_a;
                            state_q  <= StMulAdd;
`else
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_flags <= '0;
                            state_q   <= StDone;
`endif
                        end
                    end
                end
                StExec: begin
                    res_q   <= fu_d;
                    state_q <= StFlag;
                end
                StFlag: begin
                    // Flags are registered inside the unit, so they trail D by one cycle.
                    rsp_flags <= fu_flags;
                    rsp_data  <= res_q;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    wb_q      <= 1'b1;
                    fu_fs     <= FS_HOLD;
                    state_q   <= StDone;
                end
`ifdef FUNCUNIT_CTRL_MUL_EN
                StMulAdd: begin
                    if (mplier_q[0]) begin
                        acc_q <= fu_d;
                    end
                    fu_fs   <= FS_SHL;
                    fu_a    <= '0;
                    fu_b    <= mcand_q;
                    state_q <= StMulShl;
                end
                StMulShl: begin
                    mcand_q  <= fu_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if ((mplier_q[DATA_W-1:1] == '0) || (cnt_q == CNT_W'(MUL_ITER - 1))) begin
                        fu_fs     <= FS_HOLD;
                        rsp_data  <= acc_q;
                        rsp_flags <= pack_flags(1'b0, 1'b0, acc_q[DATA_W-1], acc_q == '0);
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        wb_q      <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        // Next add uses the shifted multiplier bit and the freshly shifted mcand.
                        fu_fs   <= mplier_q[1] ? FS_ADD : FS_HOLD;
                        fu_a    <= acc_q;
                        fu_b    <= fu_d;
                        state_q <= StMulAdd;
                    end
                end
`endif
                StDone: begin
                    wb_q <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    fu_fs     <= FS_HOLD;
                    cmd_ready <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_funcunit_ctrl.sv
// Directed bench for funcunit_ctrl with a behavioural function unit and a response scoreboard.
// Multiply cases run when FUNCUNIT_CTRL_MUL_EN is defined, the rejection path otherwise.
`timescale 1ns/1ps
module tb_funcunit_ctrl;

    logic        CLK;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_fs;
    logic        cmd_mul;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_srca;
    logic [2:0]  cmd_srcb;
    logic        cmd_imm_sel;
    logic [15:0] cmd_imm;
    logic [3:0]  fu_fs;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [15:0] fu_d;
    logic [3:0]  fu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    funcunit_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_fs      (cmd_fs),
        .cmd_mul     (cmd_mul),
        .cmd_dst     (cmd_dst),
        .cmd_srca    (cmd_srca),
        .cmd_srcb    (cmd_srcb),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .fu_fs       (fu_fs),
        .fu_a        (fu_a),
        .fu_b        (fu_b),
        .fu_d        (fu_d),
        .fu_flags    (fu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .rsp_err     (rsp_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Function unit model: returns {V,C,N,Z,D}.
    function automatic logic [19:0] fu_model(input logic [3:0] fs, input logic [15:0] a,
                                             input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] bop;
        logic [15:0] d;
        logic        cin, arith, v, c;
        arith = 1'b1;
        bop   = 16'h0;
        cin   = 1'b0;
        case (fs)
            4'h1: cin = 1'b1;
            4'h2: bop = b;
            4'h3: begin bop = b; cin = 1'b1; end
            4'h4: bop = ~b;
            4'h5: begin bop = ~b; cin = 1'b1; end
            4'h6: bop = 16'hFFFF;
            4'h0, 4'h7: bop = 16'h0;
            default: arith = 1'b0;
        endcase
        s = {1'b0, a} + {1'b0, bop} + {16'h0, cin};
        if (arith) begin
            d = s[15:0];
            c = s[16];
            v = (a[15] == bop[15]) && (d[15] != a[15]);
        end else begin
            c = 1'b0;
            v = 1'b0;
            case (fs)
                4'h8:    d = a & b;
                4'h9:    d = a | b;
                4'hA:    d = a ^ b;
                4'hB:    d = ~a;
                4'hC:    d = b;
                4'hD:    d = b >> 1;
                4'hE:    d = b << 1;
                default: d = 16'h0;
            endcase
        end
        return {v, c, d[15], d == 16'h0, d};
    endfunction

    logic [19:0] fu_out;
    assign fu_out = fu_model(fu_fs, fu_a, fu_b);
    assign fu_d   = fu_out[15:0];

    always @(posedge CLK or negedge RESET) begin
        if (!RESET)               fu_flags <= 4'h0;
        else if (fu_fs != 4'hF)   fu_flags <= fu_out[19:16];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        logic        err;
        int          lat;   // edges from accept edge (inclusive) to rsp_valid; 0 = not checked
    } exp_t;

    exp_t scb[$];
    int   total = 0;
    int   bad   = 0;
    int   accept_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_rsp(input logic [15:0] d, input logic [3:0] f, input logic e,
                              input int lat);
        exp_t x;
        x.data  = d;
        x.flags = f;
        x.err   = e;
        x.lat   = lat;
        scb.push_back(x);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input string tag, input logic mul, input logic [3:0] fs,
                        input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb,
                        input logic isel, input logic [15:0] imm);
        int n = 0;
        cmd_mul = mul; cmd_fs = fs; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_valid = 1'b1;
        while (!cmd_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "/accept"}, 32'(cmd_ready), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic collect(input string tag);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "/valid"}, 32'(rsp_valid), 32'd1);
        if (scb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: response with no expected entry", tag);
        end else begin
            e = scb.pop_front();
            check({tag, "/data"}, 32'(rsp_data), 32'(e.data));
            check({tag, "/flags"}, 32'(rsp_flags), 32'(e.flags));
            check({tag, "/err"}, 32'(rsp_err), 32'(e.err));
            if (e.lat > 0) check({tag, "/latency"}, 32'(cyc - accept_cyc + 1), 32'(e.lat));
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        rsp_ready = 1'b0;
        check({tag, "/idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic mul, input logic [3:0] fs,
                      input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb,
                      input logic isel, input logic [15:0] imm, input logic [15:0] d,
                      input logic [3:0] f, input logic e, input int lat);
        expect_rsp(d, f, e, lat);
        send(tag, mul, fs, dst, sa, sb, isel, imm);
        collect(tag);
    endtask

    // Read a register through a transfer-A op with dst=R0.
    task automatic read_reg(input logic [2:0] r, input logic [15:0] want);
        op($sformatf("rd_r%0d", r), 1'b0, 4'h0, 3'd0, r, 3'd0, 1'b0, 16'h0, want,
           {2'b00, want[15], want == 16'h0}, 1'b0, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; cmd_valid = 1'b0; cmd_fs = 4'h0; cmd_mul = 1'b0; cmd_dst = 3'd0;
        cmd_srca = 3'd0; cmd_srcb = 3'd0; cmd_imm_sel = 1'b0; cmd_imm = 16'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst/cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_data", 32'(rsp_data), 32'd0);
        check("rst/rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/fu_fs", 32'(fu_fs), 32'hF);
        check("rst/fu_a", 32'(fu_a), 32'd0);
        check("rst/fu_b", 32'(fu_b), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // Loads, add, decrement to zero and below, same-source add, dst==src
        op("ld_r1", 1'b0, 4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 16'h0005, 4'b0000, 1'b0, 3);
        op("ld_r2", 1'b0, 4'hC, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 16'h0003, 4'b0000, 1'b0, 3);
        op("add", 1'b0, 4'h2, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0008, 4'b0000, 1'b0, 3);
        op("ld_r1b", 1'b0, 4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0001, 16'h0001, 4'b0000, 1'b0, 3);
        op("dec1", 1'b0, 4'h6, 3'd4, 3'd1, 3'd0, 1'b0, 16'h0, 16'h0000, 4'b0101, 1'b0, 3);
        op("dec0", 1'b0, 4'h6, 3'd4, 3'd4, 3'd0, 1'b0, 16'h0, 16'hFFFF, 4'b0010, 1'b0, 3);
        op("dbl", 1'b0, 4'h2, 3'd5, 3'd3, 3'd3, 1'b0, 16'h0, 16'h0010, 4'b0000, 1'b0, 3);
        op("inc_self", 1'b0, 4'h1, 3'd5, 3'd5, 3'd0, 1'b0, 16'h0, 16'h0011, 4'b0000, 1'b0, 3);
        read_reg(3'd5, 16'h0011);
        read_reg(3'd4, 16'hFFFF);

`ifdef FUNCUNIT_CTRL_MUL_EN
        op("ld7", 1'b0, 4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0007, 16'h0007, 4'b0000, 1'b0, 3);
        op("mul7x6", 1'b1, 4'h0, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0006, 16'h002A, 4'b0000, 1'b0, 7);
        op("ld1234", 1'b0, 4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, 16'h1234, 4'b0000, 1'b0, 3);
        op("mul_x0", 1'b1, 4'h0, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0000, 16'h0000, 4'b0001, 1'b0, 3);
        op("ldffff", 1'b0, 4'hC, 3'd2, 3'd0, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF, 4'b0010, 1'b0, 3);
        op("mul_ff", 1'b1, 4'h0, 3'd5, 3'd2, 3'd2, 1'b0, 16'h0, 16'h0001, 4'b0000, 1'b0, 33);
        read_reg(3'd5, 16'h0001);
`else
        op("err_mul", 1'b1, 4'h2, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0, 16'h0000, 4'b0000, 1'b1, 1);
        read_reg(3'd1, 16'h0001);
`endif

        // Backpressure: response held while a second command waits
        op("ld_r2c", 1'b0, 4'hC, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003, 16'h0003, 4'b0000, 1'b0, 3);
        expect_rsp(16'h8002, 4'b1010, 1'b0, 0);
        send("bp", 1'b0, 4'h2, 3'd6, 3'd2, 3'd0, 1'b1, 16'h7FFF);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge CLK);
                n++;
            end
        end
        check("bp/latency", 32'(cyc - accept_cyc + 1), 32'd3);
        cmd_mul = 1'b0; cmd_fs = 4'h0; cmd_dst = 3'd7; cmd_srca = 3'd6; cmd_imm_sel = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("bp/hold_data", 32'(rsp_data), 32'h8002);
            check("bp/hold_valid", 32'(rsp_valid), 32'd1);
            check("bp/hold_ready", 32'(cmd_ready), 32'd0);
        end
        collect("bp");
        expect_rsp(16'h8002, 4'b0010, 1'b0, 3);
        @(posedge CLK);
        @(negedge CLK);
        accept_cyc = cyc;
        cmd_valid  = 1'b0;
        collect("bp_next");

        // Writes to R0 are discarded
        op("ld_r0", 1'b0, 4'hC, 3'd0, 3'd0, 3'd0, 1'b1, 16'hABCD, 16'hABCD, 4'b0010, 1'b0, 3);
        read_reg(3'd0, 16'h0000);

        // Reset in the middle of an operation
`ifdef FUNCUNIT_CTRL_MUL_EN
        op("ld_ff", 1'b0, 4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FF, 16'h00FF, 4'b0000, 1'b0, 3);
        send("rst_op", 1'b1, 4'h0, 3'd6, 3'd1, 3'd0, 1'b1, 16'h00FF);
`else
        send("rst_op", 1'b0, 4'h2, 3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
`endif
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_op/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_op/cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_op/fu_fs", 32'(fu_fs), 32'hF);
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_op/no_rsp", 32'(rsp_valid), 32'd0);
        for (int i = 1; i < 8; i++) read_reg(3'(i), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
